// File: rtl/adc_rx_pkg.sv
// Shared types and constants for the I2S ADC receiver: FSM states, register map, status layout.
// No logic; the helper function only packs the status word.
// No flow control here; the users of the package own all timing.
package adc_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DELAY_L,
        ST_SHIFT_L,
        ST_DELAY_R,
        ST_SHIFT_R,
        ST_PUSH
    } state_t;

    localparam logic ADDR_DATA = 1'b0;
    localparam logic ADDR_CTRL = 1'b1;

    localparam int SAMPLE_W = 16;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_CLEAR  = 1;
    localparam int CTRL_FLUSH  = 2;

    localparam int STAT_ENABLE      = 0;
    localparam int STAT_NOT_EMPTY   = 1;
    localparam int STAT_FULL        = 2;
    localparam int STAT_OVERFLOW    = 3;
    localparam int STAT_FRAME_ERR   = 4;
    localparam int STAT_OVF_CNT_LSB = 8;
    localparam int STAT_LEVEL_LSB   = 16;

    function automatic logic [31:0] pack_status(
        input logic        enable,
        input logic        not_empty,
        input logic        full,
        input logic        overflow,
        input logic        frame_err,
        input logic [7:0]  ovf_cnt,
        input logic [15:0] level
    );
        logic [31:0] s;
        s                           = '0;
        s[STAT_ENABLE]              = enable;
        s[STAT_NOT_EMPTY]           = not_empty;
        s[STAT_FULL]                = full;
        s[STAT_OVERFLOW]            = overflow;
        s[STAT_FRAME_ERR]           = frame_err;
        s[STAT_OVF_CNT_LSB +: 8]    = ovf_cnt;
        s[STAT_LEVEL_LSB +: 16]     = level;
        return s;
    endfunction

endpackage

// File: rtl/adc_sample_receiver_if.sv
// Avalon-MM slave bus of the ADC receiver: word address 0 = sample data, 1 = control/status.
// Zero read latency: readdata is valid in the same cycle as read.
// No waitrequest; the slave never stalls the master.
interface adc_sample_receiver_if;
    logic        address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, read, write, writedata,
        input  readdata
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata
    );
endinterface

// File: rtl/adc_rx_fifo.sv
// Generic synchronous FIFO with push/pop/flush and full/empty/level reporting.
// Head word is combinational (zero read latency); push to level/empty visible next cycle.
// Push on full is refused unless a pop happens in the same cycle.
module adc_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_dat_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           head_dat_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o    = (cnt_q == '0);
    assign full_o     = (cnt_q == FULL_CNT);
    assign level_o    = cnt_q;
    assign head_dat_o = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/adc_sample_receiver.sv
// I2S ADC receiver: 16-bit stereo frames into a FIFO read over Avalon-MM; ADC_RX_OVF_COUNT_EN adds a drop counter.
// Latency: push a few clocks after the closing lrck fall (synchronizer), sample_ready 1 clock after push, readdata combinational.
// Backpressure: none toward the codec; frames arriving at a full FIFO are dropped and flagged.
module adc_sample_receiver
    import adc_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    adc_sample_receiver_if.slave  avs,
    input  logic                  bclk,
    input  logic                  lrck,
    input  logic                  adcdat,
    output logic                  sample_ready
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic bclk_meta_q, bclk_sync_q, bclk_prev_q;
    logic lrck_meta_q, lrck_sync_q, lrck_prev_q;
    logic adat_meta_q, adat_sync_q;
    logic bclk_rise, lrck_rise, lrck_fall, lrck_edge;

    state_t              state_q;
    logic [3:0]          bit_cnt_q;
    logic                done_q;
    logic [SAMPLE_W-1:0] left_q;
    logic [SAMPLE_W-1:0] right_q;
    logic                push_q;
    logic                ferr_evt_q;

    logic        enable_q;
    logic        overflow_q;
    logic        frame_err_q;
    logic [7:0]  ovf_cnt;

    logic        wr_ctrl, clear, flush, rd_data, pop_ok, drop;
    logic [31:0] head_dat;
    logic        fifo_full, fifo_empty;
    logic [AW:0] fifo_level;
    logic        unused_wdat;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bclk_meta_q <= 1'b0;
            bclk_sync_q <= 1'b0;
            bclk_prev_q <= 1'b0;
            lrck_meta_q <= 1'b0;
            lrck_sync_q <= 1'b0;
            lrck_prev_q <= 1'b0;
            adat_meta_q <= 1'b0;
            adat_sync_q <= 1'b0;
        end else begin
            bclk_meta_q <= bclk;
            bclk_sync_q <= bclk_meta_q;
            bclk_prev_q <= bclk_sync_q;
            lrck_meta_q <= lrck;
            lrck_sync_q <= lrck_meta_q;
            lrck_prev_q <= lrck_sync_q;
            adat_meta_q <= adcdat;
            adat_sync_q <= adat_meta_q;
        end
    end

    // adcdat runs through the same depth as bclk, so it lines up with the detected rise.
    assign bclk_rise = bclk_sync_q & ~bclk_prev_q;
    assign lrck_rise = lrck_sync_q & ~lrck_prev_q;
    assign lrck_fall = ~lrck_sync_q & lrck_prev_q;
    assign lrck_edge = lrck_sync_q ^ lrck_prev_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            done_q     <= 1'b0;
            left_q     <= '0;
            right_q    <= '0;
            push_q     <= 1'b0;
            ferr_evt_q <= 1'b0;
        end else begin
            push_q     <= 1'b0;
            ferr_evt_q <= 1'b0;
            if (!enable_q) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: state_q <= ST_SYNC;
                    ST_SYNC: if (lrck_fall) state_q <= ST_DELAY_L;
                    ST_DELAY_L, ST_DELAY_R: begin
                        if (lrck_edge) begin
                            state_q    <= ST_SYNC;
                            ferr_evt_q <= 1'b1;
                        end else if (bclk_rise) begin
                            state_q   <= (state_q == ST_DELAY_L) ? ST_SHIFT_L : ST_SHIFT_R;
                            bit_cnt_q <= '0;
                            done_q    <= 1'b0;
                        end
                    end
                    ST_SHIFT_L: begin
                        if (lrck_edge) begin
                            if (done_q && lrck_rise) begin
                                state_q <= ST_DELAY_R;
                            end else begin
                                state_q    <= ST_SYNC;
                                ferr_evt_q <= 1'b1;
                            end
                        end else if (bclk_rise && !done_q) begin
                            left_q    <= {left_q[SAMPLE_W-2:0], adat_sync_q};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            done_q    <= (bit_cnt_q == 4'd15);
                        end
                    end
                    ST_SHIFT_R: begin
                        if (lrck_edge) begin
                            if (done_q && lrck_fall) begin
                                state_q <= ST_PUSH;
                                push_q  <= 1'b1;
                            end else begin
                                state_q    <= ST_SYNC;
                                ferr_evt_q <= 1'b1;
                            end
                        end else if (bclk_rise && !done_q) begin
                            right_q   <= {right_q[SAMPLE_W-2:0], adat_sync_q};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            done_q    <= (bit_cnt_q == 4'd15);
                        end
                    end
                    ST_PUSH: begin
                        // The lrck fall that closed the frame also opens the next left half.
                        if (bclk_rise) begin
                            state_q   <= ST_SHIFT_L;
                            bit_cnt_q <= '0;
                            done_q    <= 1'b0;
                        end else begin
                            state_q <= ST_DELAY_L;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign wr_ctrl = avs.write && (avs.address == ADDR_CTRL);
    assign clear   = wr_ctrl && avs.writedata[CTRL_CLEAR];
    assign flush   = wr_ctrl && avs.writedata[CTRL_FLUSH];
    assign rd_data = avs.read && (avs.address == ADDR_DATA);
    assign pop_ok  = rd_data && !fifo_empty;
    assign drop    = push_q && fifo_full && !pop_ok && !flush;

    assign unused_wdat = ^avs.writedata[31:3];

    adc_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_i     (push_q),
        .push_dat_i ({left_q, right_q}),
        .pop_i      (rd_data),
        .flush_i    (flush),
        .head_dat_o (head_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (fifo_level)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            enable_q    <= 1'b0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (wr_ctrl) enable_q <= avs.writedata[CTRL_ENABLE];
            if (clear) begin
                overflow_q  <= 1'b0;
                frame_err_q <= 1'b0;
            end else begin
                if (drop)       overflow_q  <= 1'b1;
                if (ferr_evt_q) frame_err_q <= 1'b1;
            end
        end
    end

`ifdef ADC_RX_OVF_COUNT_EN
    logic [7:0] ovf_cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ovf_cnt_q <= '0;
        end else if (clear) begin
            ovf_cnt_q <= '0;
        end else if (drop && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_q <= ovf_cnt_q + 8'd1;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`else
    assign ovf_cnt = 8'd0;
`endif

    assign sample_ready = !fifo_empty;

    always_comb begin
        avs.readdata = '0;
        if (avs.read) begin
            if (avs.address == ADDR_DATA) begin
                if (!fifo_empty) avs.readdata = head_dat;
            end else begin
                avs.readdata = pack_status(enable_q, !fifo_empty, fifo_full, overflow_q,
                                           frame_err_q, ovf_cnt, 16'(fifo_level));
            end
        end
    end

endmodule

// File: tb/tb_adc_sample_receiver.sv
// Bench for adc_sample_receiver: random I2S frames against a frame-level FIFO/status model.
// Build with or without ADC_RX_OVF_COUNT_EN; the model follows the same macro.
module tb_adc_sample_receiver;
    localparam int DEPTH = 4;
    localparam int HALF  = 3;

    logic clock  = 1'b0;
    logic reset  = 1'b0;
    logic bclk   = 1'b0;
    logic lrck   = 1'b1;
    logic adcdat = 1'b0;
    logic sample_ready;

    adc_sample_receiver_if avs();

    adc_sample_receiver #(.FIFO_DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .avs          (avs),
        .bclk         (bclk),
        .lrck         (lrck),
        .adcdat       (adcdat),
        .sample_ready (sample_ready)
    );

    always #5 clock = ~clock;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    logic        m_en, m_ovf, m_ferr;
    int          m_drops;
    logic        carry = 1'b0;
    int          push_lat = 4;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [7:0] c;
`ifdef ADC_RX_OVF_COUNT_EN
        c = (m_drops > 255) ? 8'hFF : 8'(m_drops);
`else
        c = 8'h00;
`endif
        return {16'(exp_q.size()), c, 3'b000, m_ferr, m_ovf,
                exp_q.size() == DEPTH, exp_q.size() != 0, m_en};
    endfunction

    task automatic model_frame(input logic [15:0] l, input logic [15:0] r);
        if (exp_q.size() < DEPTH) exp_q.push_back({l, r});
        else begin
            m_ovf = 1'b1;
            m_drops++;
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic bclk_cycle(input logic lr, input logic d);
        bclk   = 1'b0;
        lrck   = lr;
        adcdat = d;
        wait_cyc(HALF);
        bclk = 1'b1;
        wait_cyc(HALF);
    endtask

    // One half-frame of `slot` bclks; data MSB starts on the second bclk (I2S delay).
    task automatic send_half(input logic lr, input logic [15:0] data, input logic [15:0] pad, input int slot);
        logic [31:0] w;
        w = {data, pad} >> (32 - slot);
        for (int i = 0; i < slot; i++) bclk_cycle(lr, (i == 0) ? carry : w[slot - i]);
        carry = w[0];
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int slot);
        send_half(1'b0, l, 16'($urandom), slot);
        send_half(1'b1, r, 16'($urandom), slot);
        model_frame(l, r);
    endtask

    // Final lrck fall closes the last frame; bclk is then held still.
    task automatic close_stream();
        bclk   = 1'b0;
        lrck   = 1'b0;
        adcdat = carry;
    endtask

    task automatic bus_write(input logic addr, input logic [31:0] data);
        avs.address   = addr;
        avs.writedata = data;
        avs.write     = 1'b1;
        wait_cyc(1);
        avs.write     = 1'b0;
    endtask

    task automatic bus_read(input logic addr, output logic [31:0] data);
        avs.address = addr;
        avs.read    = 1'b1;
        #2;
        data = avs.readdata;
        wait_cyc(1);
        avs.read    = 1'b0;
    endtask

    task automatic restart();
        bus_write(1'b1, 32'h6);
        exp_q.delete();
        m_ovf   = 1'b0;
        m_ferr  = 1'b0;
        m_drops = 0;
        bus_write(1'b1, 32'h1);
        m_en = 1'b1;
        repeat (4) bclk_cycle(1'b1, 1'($urandom));
    endtask

    task automatic check_status(input string tag);
        logic [31:0] v;
        bus_read(1'b1, v);
        expect_eq(tag, v, model_status());
        expect_eq({tag, "_ready"}, {31'd0, sample_ready}, {31'd0, exp_q.size() != 0});
    endtask

    task automatic drain(input string tag);
        logic [31:0] v, e;
        int n;
        n = exp_q.size();
        for (int i = 0; i <= n; i++) begin
            bus_read(1'b0, v);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'h0;
            expect_eq(tag, v, e);
        end
        expect_eq({tag, "_ready"}, {31'd0, sample_ready}, 32'd0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [15:0] l5, r5, r24;
        int n, k;

        avs.address = 1'b0; avs.read = 1'b0; avs.write = 1'b0; avs.writedata = '0;
        m_en = 1'b0; m_ovf = 1'b0; m_ferr = 1'b0; m_drops = 0;

        wait_cyc(3);
        expect_eq("rst_ready", {31'd0, sample_ready}, 32'd0);
        expect_eq("rst_rdata", avs.readdata, 32'd0);
        reset = 1'b1;
        wait_cyc(2);
        check_status("rst_status");
        bus_read(1'b0, v);
        expect_eq("rst_empty_read", v, 32'd0);

        // Single known frame; also measure lrck-fall-to-sample_ready cycles.
        restart();
        send_frame(16'hA5C3, 16'h3C5A, 32);
        close_stream();
        k = 0;
        while (!sample_ready && k < 64) begin
            @(posedge clock);
            #1;
            k++;
        end
        expect_eq("single_ready_rise", {31'd0, sample_ready}, 32'd1);
        push_lat = (k < 64) ? k : 4;
        wait_cyc(10);
        bus_read(1'b0, v);
        expect_eq("single_word", v, 32'hA5C33C5A);
        void'(exp_q.pop_front());
        expect_eq("single_ready_fall", {31'd0, sample_ready}, 32'd0);
        bus_read(1'b0, v);
        expect_eq("single_empty_read", v, 32'd0);

        // Random bursts; the first one overruns the FIFO by exactly one frame.
        for (int r = 0; r < 3; r++) begin
            restart();
            n = (r == 0) ? 5 : $urandom_range(1, 6);
            repeat (n) send_frame(16'($urandom), 16'($urandom), 32);
            close_stream();
            wait_cyc(20);
            check_status("burst_status");
            drain("burst_read");
        end

        // Full FIFO: read lands on the push cycle of the fifth frame.
        restart();
        repeat (4) send_frame(16'($urandom), 16'($urandom), 32);
        l5 = 16'($urandom);
        r5 = 16'($urandom);
        send_half(1'b0, l5, 16'($urandom), 32);
        send_half(1'b1, r5, 16'($urandom), 32);
        close_stream();
        repeat (push_lat - 1) @(posedge clock);
        #1;
        avs.address = 1'b0;
        avs.read    = 1'b1;
        #2;
        v = avs.readdata;
        @(posedge clock);
        #1;
        avs.read = 1'b0;
        expect_eq("pushpop_oldest", v, exp_q.pop_front());
        exp_q.push_back({l5, r5});
        wait_cyc(10);
        check_status("pushpop_status");
        drain("pushpop_read");

        // Left half cut after 9 data bits, then a clean frame.
        restart();
        send_half(1'b0, 16'($urandom), 16'($urandom), 10);
        m_ferr = 1'b1;
        send_half(1'b1, 16'($urandom), 16'($urandom), 32);
        send_frame(16'h1234, 16'h5678, 32);
        close_stream();
        wait_cyc(20);
        check_status("ferr_status");
        bus_read(1'b0, v);
        expect_eq("ferr_next_word", v, 32'h12345678);
        void'(exp_q.pop_front());
        bus_write(1'b1, 32'h3);
        m_ferr = 1'b0;
        check_status("ferr_cleared");

        // 24-bit slots: only the top 16 bits of each channel are kept.
        restart();
        r24 = 16'($urandom);
        send_frame(16'h8001, r24, 24);
        close_stream();
        wait_cyc(20);
        check_status("w24_status");
        bus_read(1'b0, v);
        expect_eq("w24_left", {16'd0, v[31:16]}, 32'h8001);
        expect_eq("w24_word", v, exp_q.pop_front());

        // Reset in the middle of the right half of the second frame.
        restart();
        send_frame(16'($urandom), 16'($urandom), 32);
        send_half(1'b0, 16'($urandom), 16'($urandom), 32);
        repeat (8) bclk_cycle(1'b1, 1'($urandom));
        reset = 1'b0;
        wait_cyc(3);
        reset = 1'b1;
        exp_q.delete();
        m_en = 1'b0; m_ovf = 1'b0; m_ferr = 1'b0; m_drops = 0;
        repeat (8) bclk_cycle(1'b1, 1'($urandom));
        close_stream();
        wait_cyc(20);
        bus_read(1'b1, v);
        expect_eq("midrst_status", v, 32'd0);
        expect_eq("midrst_ready", {31'd0, sample_ready}, 32'd0);
        bus_read(1'b0, v);
        expect_eq("midrst_data", v, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adc_sample_receiver.md
ADC_SAMPLE_RECEIVER -- requirements
Module: adc_sample_receiver

Interface
REQ-001 Parameter FIFO_DEPTH, 4, stereo-frame FIFO entries; power of two, 2..16.
REQ-002 clock  in  1  system clock; single clock domain.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 address  in  1  Avalon word address: 0 = sample data, 1 = control/status.
REQ-005 read  in  1  Avalon read strobe.
REQ-006 write  in  1  Avalon write strobe.
REQ-007 writedata  in  32  Avalon write data.
REQ-008 readdata  out  32  Avalon read data, read latency 0.
REQ-009 bclk  in  1  codec bit clock, asynchronous to clock.
REQ-010 lrck  in  1  codec frame clock: low = left, high = right.
REQ-011 adcdat  in  1  codec ADC serial data, I2S format, MSB first.
REQ-012 sample_ready  out  1  high while FIFO non-empty.

Function
REQ-013 bclk, lrck and adcdat SHALL each pass a 2-flop synchronizer; edges are detected on the synchronized copies.
REQ-014 adcdat SHALL be sampled only on a detected synchronized bclk rising edge.
REQ-015 FSM states SHALL be IDLE, SYNC, DELAY_L, SHIFT_L, DELAY_R, SHIFT_R, PUSH.
REQ-016 IDLE: enable=1 -> SYNC. Disable from any state -> IDLE next cycle; partial frame discarded.
REQ-017 SYNC: lrck falling edge -> DELAY_L.
REQ-018 DELAY_L/DELAY_R: skip one bclk rising edge (I2S 1-bit delay) -> SHIFT_L/SHIFT_R; 4-bit bit counter cleared.
REQ-019 SHIFT_x: shift 16 bits MSB first; further bits in the half-frame are ignored.
REQ-020 SHIFT_L, 16 bits done, then lrck rising edge -> DELAY_R.
REQ-021 SHIFT_R, 16 bits done, then lrck falling edge -> PUSH.
REQ-022 lrck edge before 16 bits captured: discard frame, set frame_err sticky, -> SYNC.
REQ-023 PUSH: write {left[15:0], right[15:0]} to FIFO for one cycle, -> DELAY_L. The lrck falling edge that caused PUSH SHALL count as the next frame start.
REQ-024 PUSH with FIFO full: word dropped, FIFO unchanged, overflow sticky set.
REQ-025 Read, address 0, FIFO non-empty: readdata = head word; pop on same cycle.
REQ-026 Read, address 0, FIFO empty: readdata = 0, no pop.
REQ-027 Same-cycle push and pop on a full FIFO: both succeed; no overflow.
REQ-028 Status (address 1): [0] enable, [1] not-empty, [2] full, [3] overflow, [4] frame_err, [7:5] 0, [15:8] overflow count, [31:16] fill level.
REQ-029 Write to address 1: [0] sets enable; [1]=1 clears overflow, frame_err and overflow count; [2]=1 flushes FIFO. Write to address 0 is ignored.
REQ-030 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-031 Push-to-sample_ready latency SHALL be 1 cycle.

Reset
REQ-032 Reset SHALL force FSM=IDLE, enable=0, FIFO empty, pointers=0, stickies=0, counters=0, synchronizers=0.
REQ-033 Reset values SHALL be readdata=0 and sample_ready=0.
REQ-034 Reset asserted mid-frame SHALL abort the frame; no partial word reaches the FIFO.

Configuration
REQ-035 With macro ADC_RX_OVF_COUNT_EN defined, status[15:8] SHALL be an 8-bit saturating (holds 255) count of dropped frames.
REQ-036 Without ADC_RX_OVF_COUNT_EN, status[15:8] SHALL read 0 and no counter SHALL be synthesized.

Structure
REQ-037 Shared package adc_rx_pkg SHALL hold the FSM state enum, address constants (ADDR_DATA, ADDR_CTRL) and status/control bit positions.
REQ-038 The FIFO SHALL be sub-module adc_rx_fifo (parameterized depth, 32-bit, push/pop/flush, full/empty/level).

Verification
REQ-039 Enable; one I2S frame L=16'hA5C3, R=16'h3C5A -> sample_ready rises; read address 0 = 32'hA5C33C5A; then empty.
REQ-040 Five frames, no reads, depth 4 -> status full=1, overflow=1, count=1 (macro on) or status[15:8]=0 (macro off); reads return frames 1-4.
REQ-041 lrck toggles after 9 left bits -> frame_err=1, no push; next valid frame 32'h12345678 captured correctly.
REQ-042 Reset pulled low mid-right-channel, then released, no reads -> status reads 0, sample_ready=0.
REQ-043 24-bit codec frames (24 bclk per half) with left MSBs 16'h8001 -> only top 16 bits stored; read returns 16'h8001 in [31:16].
REQ-044 FIFO full; push and read in the same cycle -> oldest word returned, new word stored, overflow stays 0.
